// File: rtl/inst_encoder_loader.sv
// Packs instruction fields into 16-bit words and writes them to imem.
// Optional checksum output: INST_ENCODER_CHECKSUM_EN.
module inst_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [1:0]        in_rs,
  input  logic [1:0]        in_rt,
  input  logic [1:0]        in_rd,
  input  logic [7:0]        in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
`ifdef INST_ENCODER_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    ERR
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic              start_ok;
  logic              xfer;
  logic              legal;
  logic              is_r;
  logic [15:0]       word;

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign start_ok = start & ((state == IDLE) | (state == ERR));
  assign xfer     = in_valid & in_ready;
  assign legal    = (in_opcode <= 4'hD);

  // Field packing: R-format carries rd, I-format carries imm.
  always_comb begin
    is_r = in_opcode inside {4'h2, 4'h4, 4'h5, 4'h7, 4'hB, 4'hC, 4'hD};
    if (is_r)
      word = {in_opcode, in_rs, in_rt, in_rd, 6'b0};
    else
      word = {in_opcode, in_rs, in_rt, in_imm};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state selection.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, ERR: begin
        if (start_ok)
          state_nx = (num_words == '0) ? DONE : RUN;
      end
      RUN: begin
        if (xfer) begin
          if (!legal)
            state_nx = ERR;
          else if (remaining == (ADDR_W+1)'(1))
            state_nx = DONE;
        end
      end
      DONE: state_nx = IDLE;
    endcase
  end

  // Batch bookkeeping and the registered imem write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      remaining     <= '0;
      words_written <= '0;
      err           <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
`ifdef INST_ENCODER_CHECKSUM_EN
      checksum      <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (start_ok) begin
        ptr           <= base_addr;
        remaining     <= num_words;
        words_written <= '0;
        err           <= 1'b0;
`ifdef INST_ENCODER_CHECKSUM_EN
        checksum      <= '0;
`endif
      end else if (xfer) begin
        if (legal) begin
          imem_we       <= 1'b1;
          imem_addr     <= ptr;
          imem_wdata    <= word;
          ptr           <= ptr + ADDR_W'(1);
          remaining     <= remaining - (ADDR_W+1)'(1);
          words_written <= words_written + (ADDR_W+1)'(1);
`ifdef INST_ENCODER_CHECKSUM_EN
          checksum      <= checksum ^ word;
`endif
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Randomised and directed bench for inst_encoder_loader
// against a transaction-level reference model.
module tb_inst_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  num_words = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = '0;
  logic [1:0]  in_rs = '0;
  logic [1:0]  in_rt = '0;
  logic [1:0]  in_rd = '0;
  logic [7:0]  in_imm = '0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  words_written;
`ifdef INST_ENCODER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int total = 0;
  int bad = 0;

  inst_encoder_loader #(.ADDR_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base_addr(base_addr),
    .num_words(num_words),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_opcode(in_opcode),
    .in_rs(in_rs),
    .in_rt(in_rt),
    .in_rd(in_rd),
    .in_imm(in_imm),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .busy(busy),
    .done(done),
    .err(err),
`ifdef INST_ENCODER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Reference model: batch-level view of the loader.
  bit      m_run, m_done, m_err, m_we;
  int      m_ptr, m_rem, m_ww, m_addr, m_data, m_cs;
  int      we_count;
  logic [15:0] rmask;

  function automatic int enc(int op, int rs, int rt, int rd, int imm);
    logic [15:0] msk;
    msk = 16'h38B4;
    if (msk[op[3:0]])
      return op * 4096 + rs * 1024 + rt * 256 + rd * 64;
    return op * 4096 + rs * 1024 + rt * 256 + imm;
  endfunction

  task automatic check(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_err = 0; m_we = 0;
    m_ptr = 0; m_rem = 0; m_ww = 0;
    m_addr = 0; m_data = 0; m_cs = 0;
  endtask

  task automatic check_all();
    check("imem_we", int'(imem_we), int'(m_we));
    check("imem_addr", int'(imem_addr), m_addr);
    check("imem_wdata", int'(imem_wdata), m_data);
    check("busy", int'(busy), int'(m_run));
    check("in_ready", int'(in_ready), int'(m_run));
    check("done", int'(done), int'(m_done));
    check("err", int'(err), int'(m_err));
    check("words_written", int'(words_written), m_ww);
`ifdef INST_ENCODER_CHECKSUM_EN
    check("checksum", int'(checksum), m_cs);
`endif
  endtask

  // One clock: drive, advance model across the edge, compare.
  task automatic cyc(input bit st, input int b, input int n,
                     input bit v, input int op, input int rs,
                     input int rt, input int rd, input int imm);
    bit acc;
    start = st;
    base_addr = b[7:0];
    num_words = n[8:0];
    in_valid = v;
    in_opcode = op[3:0];
    in_rs = rs[1:0];
    in_rt = rt[1:0];
    in_rd = rd[1:0];
    in_imm = imm[7:0];
    @(posedge clk);
    acc = st && !m_run && !m_done;
    m_we = 0;
    if (acc) begin
      m_ptr = b % 256; m_rem = n; m_err = 0; m_ww = 0; m_cs = 0;
      m_done = (n == 0);
      m_run = (n != 0);
    end else if (v && m_run) begin
      m_done = 0;
      if (op > 13) begin
        m_err = 1; m_run = 0;
      end else begin
        m_we = 1;
        m_addr = m_ptr;
        m_data = enc(op, rs, rt, rd, imm);
        m_cs = m_cs ^ m_data;
        m_ptr = (m_ptr + 1) % 256;
        m_rem = m_rem - 1;
        m_ww = m_ww + 1;
        if (m_rem == 0) begin
          m_run = 0; m_done = 1;
        end
      end
    end else begin
      m_done = 0;
    end
    #1;
    if (imem_we) we_count++;
    check_all();
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int b, n, op, cnt;
    model_reset();
    rmask = 16'h38B4;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check_all();

    // Basic batch with fixed expected words.
    cyc(1, 8'h10, 2, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 3, 1, 2, 0, 8'h5A);
    check("basic_w0", int'(imem_wdata), 16'h365A);
    check("basic_a0", int'(imem_addr), 8'h10);
    cyc(0, 0, 0, 1, 2, 1, 2, 3, 0);
    check("basic_w1", int'(imem_wdata), 16'h26C0);
    check("basic_a1", int'(imem_addr), 8'h11);
    check("basic_done", int'(done & imem_we), 1);
    check("basic_ww", int'(words_written), 2);
`ifdef INST_ENCODER_CHECKSUM_EN
    check("basic_cs", int'(checksum), 16'h109A);
`endif
    idle(2);

    // Back-pressure 1,0,0,1,1 with three words.
    we_count = 0;
    cyc(1, 8'h40, 3, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 8, 3, 0, 1, 8'hC3);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 2, 1, 0, 8'h11);
    cyc(0, 0, 0, 1, 13, 0, 3, 2, 8'hFF);
    check("bp_last_addr", int'(imem_addr), 8'h42);
    idle(3);
    check("bp_count", we_count, 3);

    // Address wrap.
    cyc(1, 8'hFF, 2, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1, 1, 0, 8'h01);
    check("wrap_a0", int'(imem_addr), 8'hFF);
    cyc(0, 0, 0, 1, 10, 2, 2, 0, 8'h02);
    check("wrap_a1", int'(imem_addr), 8'h00);
    idle(2);

    // Illegal opcode, then recovery.
    cyc(1, 8'h20, 3, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 1, 0, 8'h33);
    cyc(0, 0, 0, 1, 14, 0, 1, 0, 8'h44);
    check("ill_err", int'(err), 1);
    check("ill_ready", int'(in_ready), 0);
    idle(3);
    cyc(1, 8'h30, 1, 0, 0, 0, 0, 0, 0);
    check("ill_clear", int'(err), 0);
    cyc(0, 0, 0, 1, 4, 1, 1, 1, 0);
    check("ill_recover_done", int'(done), 1);
    idle(2);

    // Zero count, and start ignored during RUN.
    cyc(1, 8'h50, 0, 0, 0, 0, 0, 0, 0);
    check("zero_done", int'(done), 1);
    check("zero_we", int'(imem_we), 0);
    idle(1);
    cyc(1, 8'h60, 2, 0, 0, 0, 0, 0, 0);
    cyc(1, 8'h90, 5, 1, 6, 1, 0, 0, 8'h77);
    cyc(1, 8'h90, 5, 1, 7, 2, 3, 1, 0);
    check("ign_addr", int'(imem_addr), 8'h61);
    check("ign_done", int'(done), 1);
    idle(2);

    // Reset mid-RUN.
    cyc(1, 8'h70, 4, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 9, 1, 1, 0, 8'h12);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    we_count = 0;
    cyc(0, 0, 0, 1, 3, 0, 0, 0, 0);
    idle(2);
    check("rst_no_we", we_count, 0);

    // Random batches.
    for (int t = 0; t < 40; t++) begin
      b = $urandom_range(0, 255);
      n = $urandom_range(0, 6);
      cyc(1, b, n, 0, 0, 0, 0, 0, 0);
      cnt = 0;
      while (m_run && cnt < 60) begin
        op = ($urandom_range(0, 19) == 0) ?
             $urandom_range(14, 15) : $urandom_range(0, 13);
        cyc(0, 0, 0, $urandom_range(0, 2) != 0, op,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 255));
        cnt++;
      end
      if (m_run) check("rand_timeout", 1, 0);
      idle($urandom_range(1, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Inverse of the instruction decoder: accepts instruction fields (opcode, rs, rt, rd, imm) over a valid/ready stream and packs them into 16-bit instruction words.
- Writes the packed words into instruction memory at consecutive addresses.
- Used by the boot/test loader to fill imem before the single-cycle datapath runs.
- Programmed per batch with a start pulse, base address and word count.

Parameters:
- ADDR_W, 8, instruction memory address width in bits; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle batch start pulse; honoured only in IDLE or ERR.
- base_addr  input  ADDR_W  first imem address of the batch; latched on accepted start.
- num_words  input  ADDR_W+1  number of instructions in the batch; latched on accepted start.
- in_valid  input  1  field beat valid.
- in_ready  output  1  encoder accepts a beat.
- in_opcode  input  4  instruction opcode.
- in_rs  input  2  rs field.
- in_rt  input  2  rt field.
- in_rd  input  2  rd field.
- in_imm  input  8  immediate field.
- imem_we  output  1  imem write strobe, one cycle per word.
- imem_addr  output  ADDR_W  imem write address.
- imem_wdata  output  16  encoded instruction word.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the batch completes.
- err  output  1  sticky illegal-opcode flag.
- words_written  output  ADDR_W+1  words written since the last accepted start.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state IDLE; all outputs 0; in_ready 0; internal pointer and count registers 0.
- Reset mid-batch: takes effect immediately. No further writes occur and the batch is abandoned.
- States: IDLE, RUN, DONE, ERR.
- Accepted start (in IDLE or ERR):
  - Latch base_addr into the pointer and num_words into the remaining count.
  - Clear err and words_written.
  - If num_words = 0, go to DONE. Otherwise go to RUN.
- start in RUN or DONE: ignored.
- in_ready = 1 only in RUN. It depends only on state, never on in_valid.
- Transfer occurs when in_valid & in_ready.
- Legal opcodes (0x0–0xD):
  - I-format (opcodes 0, 1, 3, 6, 8, 9, A): word = {opcode, rs, rt, imm}. in_rd is ignored.
  - R-format (opcodes 2, 4, 5, 7, B, C, D): word = {opcode, rs, rt, rd, 6'b0}. in_imm is ignored.
- Write timing for a legal transfer in cycle T:
  - In cycle T+1: imem_we = 1, imem_addr = pointer, imem_wdata = encoded word. Latency is one cycle.
  - The pointer increments, wrapping 2^ADDR_W−1 → 0.
  - remaining decrements and words_written increments.
  - imem_we is 0 in every cycle without a preceding transfer.
- Last word (transfer when remaining = 1): next state is DONE, and in_ready is 0 from T+1.
- DONE lasts exactly one cycle, then returns to IDLE.
  - done = 1 during DONE, coinciding with the last word's imem_we.
  - For num_words = 0, done pulses in the cycle after start and no write occurs.
- Illegal opcode (0xE or 0xF) on a transfer:
  - The beat is consumed and not written.
  - err is set (sticky), state goes to ERR, in_ready drops, busy drops, and done never pulses.
  - imem_addr and imem_wdata hold their last values.
- busy = (state == RUN).
- imem_addr and imem_wdata hold their last values when imem_we = 0.

Optional Feature:
- Macro: INST_ENCODER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (16 bits), reset to 0 and cleared on an accepted start.
  - checksum updates to checksum XOR imem_wdata in the same register update that drives each imem_we, so it is valid alongside the done pulse.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst_n = 0 mid-RUN → all outputs 0 asynchronously, in_ready 0, no imem_we after release until a new start.
- Basic batch: start with base = 0x10, num = 2; beats {op 3, rs 1, rt 2, imm 0x5A}, then {op 2, rs 1, rt 2, rd 3} → required response:
  - 0x365A written to address 0x10, then 0x26C0 to 0x11.
  - done coincides with the second imem_we; words_written = 2.
  - With the macro defined, checksum = 0x109A.
- Back-pressure: in_valid toggled 1, 0, 0, 1, 1 for num = 3 → exactly three imem_we pulses, each one cycle after its transfer, at contiguous addresses.
- Wrap: ADDR_W = 8, base = 0xFF, num = 2 → writes at 0xFF, then 0x00.
- Illegal opcode: num = 3, beats op 1, op 0xE → first word written, second not written, err = 1, in_ready 0, no done; a new start clears err and the next batch completes normally.
- Zero count and ignored start: num = 0 → done in the cycle after start with no imem_we; a start pulse during RUN leaves the pointer and count unchanged.
